// File: rtl/sha3_digest_packer.sv
// Captures the leading digest lanes of the final sha3 state and streams them out
// as OUT_WIDTH-bit words over valid/ready, flagging samples dropped while busy.
module sha3_digest_packer #(
  parameter int DIGEST_LANES = 4,
  parameter int OUT_WIDTH    = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [63:0]          isa [0:4],
  input  logic [63:0]          isb [0:4],
  input  logic [63:0]          isc [0:4],
  input  logic [63:0]          isd [0:4],
  input  logic [63:0]          ise [0:4],
  input  logic                 sample,
  output logic [OUT_WIDTH-1:0] odata,
  output logic                 ovalid,
  input  logic                 iready,
  output logic                 olast,
  output logic                 obusy,
  output logic                 ooverrun
);

  localparam int WPL = (OUT_WIDTH == 32) ? 2 : 1;
  localparam int N   = DIGEST_LANES * WPL;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (DIGEST_LANES < 1 || DIGEST_LANES > 25) begin : g_bad_lanes
      $error("sha3_digest_packer: DIGEST_LANES must be in 1..25");
    end
    if (OUT_WIDTH != 32 && OUT_WIDTH != 64) begin : g_bad_width
      $error("sha3_digest_packer: OUT_WIDTH must be 32 or 64");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state_reg;
  logic [63:0]          in_lanes  [0:DIGEST_LANES-1];
  logic [63:0]          lanes_reg [0:DIGEST_LANES-1];
  logic [OUT_WIDTH-1:0] words     [0:N-1];
  logic [OUT_WIDTH-1:0] word0_in;
  logic [CW-1:0]        cnt_reg;
  logic [CW-1:0]        cnt_next;
  logic                 xfer;
  logic                 final_xfer;
  logic                 load;
  logic                 lanes_unused;

  // Lane k lives at row k/5, column k%5 of the incoming state.
  genvar gi;
  generate
    for (gi = 0; gi < DIGEST_LANES; gi++) begin : g_lane
      if (gi / 5 == 0)      begin : g_r0 assign in_lanes[gi] = isa[gi % 5]; end
      else if (gi / 5 == 1) begin : g_r1 assign in_lanes[gi] = isb[gi % 5]; end
      else if (gi / 5 == 2) begin : g_r2 assign in_lanes[gi] = isc[gi % 5]; end
      else if (gi / 5 == 3) begin : g_r3 assign in_lanes[gi] = isd[gi % 5]; end
      else                  begin : g_r4 assign in_lanes[gi] = ise[gi % 5]; end
    end
    // Word j is slice j%WPL of lane j/WPL, low half first for 32-bit output.
    for (gi = 0; gi < N; gi++) begin : g_word
      assign words[gi] = lanes_reg[gi / WPL][(gi % WPL) * OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  // Lanes beyond the digest are intentionally discarded.
  assign lanes_unused = ^{isa[0], isa[1], isa[2], isa[3], isa[4],
                          isb[0], isb[1], isb[2], isb[3], isb[4],
                          isc[0], isc[1], isc[2], isc[3], isc[4],
                          isd[0], isd[1], isd[2], isd[3], isd[4],
                          ise[0], ise[1], ise[2], ise[3], ise[4]};

  assign word0_in   = in_lanes[0][OUT_WIDTH-1:0];
  assign cnt_next   = cnt_reg + 1'b1;
  assign xfer       = ovalid && iready;
  assign final_xfer = xfer && (cnt_reg == LAST);
  // A new digest is accepted when idle or exactly as the previous one finishes.
  assign load       = sample && ((state_reg == IDLE) || final_xfer);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      odata     <= '0;
      ovalid    <= 1'b0;
      olast     <= 1'b0;
      obusy     <= 1'b0;
      ooverrun  <= 1'b0;
      for (int k = 0; k < DIGEST_LANES; k++) lanes_reg[k] <= '0;
    end else begin
      ooverrun <= sample && (state_reg == EMIT) && !final_xfer;
      if (load) begin
        state_reg <= EMIT;
        lanes_reg <= in_lanes;
        cnt_reg   <= '0;
        odata     <= word0_in;
        ovalid    <= 1'b1;
        olast     <= (N == 1);
        obusy     <= 1'b1;
      end else if (final_xfer) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        ovalid    <= 1'b0;
        olast     <= 1'b0;
        obusy     <= 1'b0;
      end else if (xfer) begin
        cnt_reg <= cnt_next;
        odata   <= words[cnt_next];
        olast   <= (cnt_next == LAST);
      end
    end
  end

endmodule

// File: doc/sha3_digest_packer.md
Name: sha3_digest_packer

Overview:
- Sits directly downstream of the last sha3 round stage.
- Captures the final 5x5 state of 64-bit lanes when the stage's good strobe is high.
- Extracts the leading DIGEST_LANES lanes and streams them out as OUT_WIDTH-bit words over a valid/ready handshake, marking the final word with olast.
- Decouples the fixed-rate round pipeline from a back-pressured consumer (FIFO, bus bridge) and flags results lost to back-pressure.

Parameters:
- DIGEST_LANES, 4, number of leading lanes forming the digest; legal range 1..25 (4 = SHA3-256, 8 = SHA3-512); elaboration $error outside range.
- OUT_WIDTH, 64, output word width; legal values 32 or 64; elaboration $error otherwise.

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- isa  input  64 x [0:4]  state row 0, lanes 0..4.
- isb  input  64 x [0:4]  state row 1, lanes 5..9.
- isc  input  64 x [0:4]  state row 2, lanes 10..14.
- isd  input  64 x [0:4]  state row 3, lanes 15..19.
- ise  input  64 x [0:4]  state row 4, lanes 20..24.
- sample  input  1  state valid this cycle; one-cycle strobe from the upstream stage.
- odata  output  OUT_WIDTH  current digest word.
- ovalid  output  1  odata valid.
- iready  input  1  consumer accepts odata this cycle.
- olast  output  1  high with the final word of a digest.
- obusy  output  1  a digest is held or being emitted.
- ooverrun  output  1  one-cycle pulse: sample arrived and was dropped.

Behaviour:
- Reset (rstn low, async): odata=0, ovalid=0, olast=0, obusy=0, ooverrun=0, word counter=0, FSM=IDLE. Reset mid-emission aborts the digest; no further words are emitted.
- Lane mapping: lane k = row k/5, column k%5.
- Capture: only lanes 0..DIGEST_LANES-1 are registered; other lanes are ignored.
- Word count: N = DIGEST_LANES*64/OUT_WIDTH.
- Word order, OUT_WIDTH=64: word j = lane j.
- Word order, OUT_WIDTH=32: word 2k = lane k[31:0], word 2k+1 = lane k[63:32].
- Transfer: occurs on a clk edge where ovalid && iready.
- IDLE state:
  - On sample: capture lanes, counter=0, go to EMIT.
  - In the next cycle: ovalid=1, odata=word 0, obusy=1. Latency from sample to first ovalid is 1 cycle.
- EMIT state, non-final transfer: counter increments; odata shows the next word in the following cycle.
- EMIT state, stall: while ovalid && !iready, odata and olast hold stable.
- EMIT state, olast: olast = ovalid && (counter == N-1).
- EMIT state, final transfer without sample: go to IDLE; ovalid, olast and obusy go to 0 in the next cycle.
- EMIT state, final transfer with sample in the same cycle: capture the new state, counter=0, stay in EMIT. Back-to-back digests have no bubble.
- Overrun: sample in EMIT without a final transfer in that cycle leaves the held digest unchanged and pulses ooverrun high for exactly the next cycle.
- Counter: width $clog2(N) (minimum 1 bit), wraps only via the explicit reset to 0 described above; it never exceeds N-1.
- N=1 (DIGEST_LANES=1, OUT_WIDTH=64): the first word is also the last, so olast=1 together with ovalid.
- iready is ignored while ovalid=0.
- Implementation target: registered outputs only; odata is driven from a mux over the captured lanes selected by the counter, registered or combinational-from-registers.

Test Plan:
- Default params: drive sample with isa={64'h0..01, 64'h0..02, 64'h0..03, 64'h0..04, 64'hFF}, iready=1 -> ovalid 1 cycle after sample; odata 1,2,3,4 on consecutive cycles; olast only with 4; 64'hFF never appears; obusy falls after the 4th transfer.
- OUT_WIDTH=32, DIGEST_LANES=4, lane0=64'hAAAABBBB_CCCCDDDD -> first two words 32'hCCCCDDDD then 32'hAAAABBBB; 8 words total; olast on the 8th.
- Back-pressure: iready low for 3 cycles on word 1 -> odata holds lane 1 value, ovalid stays 1, no counter advance; resumes on iready=1.
- Back-to-back: second sample coincident with the final transfer (iready=1) -> next cycle odata = new lane 0, no idle cycle, ooverrun=0.
- Overrun: sample during word 2 with iready=0 -> ooverrun high for 1 cycle; remaining words are from the original digest.
- Reset: deassert rstn asynchronously mid word 1 -> ovalid, olast, obusy and odata go to 0 immediately; after release, no output until the next sample.
